// File: rtl/user_tx_wr_if_mc_if.sv
// Write-request and write-response buses between the user channels, user_tx_wr_if_mc
// and the fthread arbiter.
interface user_tx_wr_if_mc_if #(
  parameter int NUM_CH   = 4,
  parameter int USER_TAG = 7,
  parameter int IF_TAG   = 9,
  parameter int ADDR_W   = 58,
  parameter int DATA_W   = 512
);
  logic [NUM_CH-1:0]          reset_interface;
  logic [NUM_CH*ADDR_W-1:0]   um_tx_wr_addr;
  logic [NUM_CH*USER_TAG-1:0] um_tx_wr_tag;
  logic [NUM_CH*DATA_W-1:0]   um_tx_data;
  logic [NUM_CH-1:0]          um_tx_wr_valid;
  logic [NUM_CH-1:0]          um_tx_wr_ready;
  logic [NUM_CH*USER_TAG-1:0] um_rx_wr_tag;
  logic [NUM_CH-1:0]          um_rx_wr_valid;
  logic [NUM_CH-1:0]          usr_tx_wr_if_empty;
  logic [NUM_CH-1:0]          ch_err;
  logic                       usr_arb_tx_wr_valid;
  logic [ADDR_W-1:0]          usr_arb_tx_wr_addr;
  logic [IF_TAG-1:0]          usr_arb_tx_wr_tag;
  logic [DATA_W-1:0]          usr_arb_tx_data;
  logic                       usr_arb_tx_wr_ready;
  logic                       usr_arb_rx_wr_valid;
  logic [IF_TAG-1:0]          usr_arb_rx_wr_tag;

  modport slave (
    input  reset_interface, um_tx_wr_addr, um_tx_wr_tag, um_tx_data, um_tx_wr_valid,
           usr_arb_tx_wr_ready, usr_arb_rx_wr_valid, usr_arb_rx_wr_tag,
    output um_tx_wr_ready, um_rx_wr_tag, um_rx_wr_valid, usr_tx_wr_if_empty, ch_err,
           usr_arb_tx_wr_valid, usr_arb_tx_wr_addr, usr_arb_tx_wr_tag, usr_arb_tx_data
  );

  modport master (
    output reset_interface, um_tx_wr_addr, um_tx_wr_tag, um_tx_data, um_tx_wr_valid,
           usr_arb_tx_wr_ready, usr_arb_rx_wr_valid, usr_arb_rx_wr_tag,
    input  um_tx_wr_ready, um_rx_wr_tag, um_rx_wr_valid, usr_tx_wr_if_empty, ch_err,
           usr_arb_tx_wr_valid, usr_arb_tx_wr_addr, usr_arb_tx_wr_tag, usr_arb_tx_data
  );
endinterface

// File: rtl/user_tx_wr_if_mc.sv
// Multi-channel user write interface: per-channel FWFT request FIFOs, round-robin issue
// onto one registered TX port, per-channel outstanding credits and response routing.
module user_tx_wr_if_mc #(
  parameter int NUM_CH          = 4,
  parameter int USER_TAG        = 7,
  parameter int IF_TAG          = 9,
  parameter int ADDR_W          = 58,
  parameter int DATA_W          = 512,
  parameter int FIFO_DEPTH_BITS = 5,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic clk,
  input  logic rst,
  user_tx_wr_if_mc_if.slave bus
);
  localparam int CH_BITS = $clog2(NUM_CH);
  localparam int DEPTH   = 2 ** FIFO_DEPTH_BITS;
  localparam int PTR_W   = FIFO_DEPTH_BITS + 1;
  localparam int ENT_W   = ADDR_W + USER_TAG + DATA_W;
  localparam int CNT_W   = 8;

  logic [ENT_W-1:0]    mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0]    wr_ptr [NUM_CH];
  logic [PTR_W-1:0]    rd_ptr [NUM_CH];
  logic [CNT_W-1:0]    out_cnt [NUM_CH];
  logic [USER_TAG-1:0] rx_tag_q [NUM_CH];
  logic [NUM_CH-1:0]   fifo_empty, fifo_full, push, eligible, pop, rsp_acc, rsp_err;
  logic [CH_BITS-1:0]  rr_ptr, reg_ch, grant_ch, rsp_ch, idx;
  logic                found, grant, reg_free;
  logic [ENT_W-1:0]    head;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign fifo_empty[c] = (wr_ptr[c] == rd_ptr[c]);
    assign fifo_full[c]  = ((wr_ptr[c] - rd_ptr[c]) == PTR_W'(DEPTH));
    assign push[c]       = bus.um_tx_wr_valid[c] & ~fifo_full[c] & ~bus.reset_interface[c];
    assign eligible[c]   = ~fifo_empty[c] & (out_cnt[c] < CNT_W'(MAX_OUTSTANDING))
                           & ~bus.reset_interface[c];
    assign pop[c]        = grant & (grant_ch == CH_BITS'(c));
    assign rsp_acc[c]    = bus.usr_arb_rx_wr_valid & (rsp_ch == CH_BITS'(c)) & (out_cnt[c] != '0);
    assign rsp_err[c]    = bus.usr_arb_rx_wr_valid & (rsp_ch == CH_BITS'(c)) & (out_cnt[c] == '0);
    assign bus.um_tx_wr_ready[c] = ~fifo_full[c];
    assign bus.um_rx_wr_tag[c*USER_TAG +: USER_TAG] = rx_tag_q[c];
    assign bus.usr_tx_wr_if_empty[c] = fifo_empty[c] & (out_cnt[c] == '0)
                                       & ~(bus.usr_arb_tx_wr_valid & (reg_ch == CH_BITS'(c)));
  end

  // Response tag bits above {ch, user_tag} carry no meaning here.
  if (IF_TAG > CH_BITS + USER_TAG) begin : g_unused
    logic unused_rsp_hi;
    assign unused_rsp_hi = ^bus.usr_arb_rx_wr_tag[IF_TAG-1:CH_BITS+USER_TAG];
  end

  assign reg_free = ~bus.usr_arb_tx_wr_valid | bus.usr_arb_tx_wr_ready;
  assign rsp_ch   = bus.usr_arb_rx_wr_tag[USER_TAG +: CH_BITS];

  always_comb begin
    found    = 1'b0;
    grant_ch = rr_ptr;
    idx      = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = rr_ptr + CH_BITS'(i);
      if (!found && eligible[idx]) begin
        found    = 1'b1;
        grant_ch = idx;
      end
    end
  end

  assign grant = found & reg_free;
  assign head  = mem[grant_ch][rd_ptr[grant_ch][FIFO_DEPTH_BITS-1:0]];

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (push[c])
        mem[c][wr_ptr[c][FIFO_DEPTH_BITS-1:0]] <= {bus.um_tx_wr_addr[c*ADDR_W +: ADDR_W],
                                                   bus.um_tx_wr_tag[c*USER_TAG +: USER_TAG],
                                                   bus.um_tx_data[c*DATA_W +: DATA_W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]   <= '0;
        rd_ptr[c]   <= '0;
        out_cnt[c]  <= '0;
        rx_tag_q[c] <= '0;
      end
      bus.um_rx_wr_valid <= '0;
      bus.ch_err         <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.reset_interface[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
          if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        end
        // Issue and accepted response in the same cycle cancel out.
        if (pop[c] && !rsp_acc[c])      out_cnt[c] <= out_cnt[c] + CNT_W'(1);
        else if (rsp_acc[c] && !pop[c]) out_cnt[c] <= out_cnt[c] - CNT_W'(1);
        if (rsp_acc[c]) rx_tag_q[c] <= bus.usr_arb_rx_wr_tag[USER_TAG-1:0];
        if (rsp_err[c])                  bus.ch_err[c] <= 1'b1;
        else if (bus.reset_interface[c]) bus.ch_err[c] <= 1'b0;
      end
      bus.um_rx_wr_valid <= rsp_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.usr_arb_tx_wr_valid <= 1'b0;
      bus.usr_arb_tx_wr_addr  <= '0;
      bus.usr_arb_tx_wr_tag   <= '0;
      bus.usr_arb_tx_data     <= '0;
      reg_ch                  <= '0;
      rr_ptr                  <= '0;
    end else if (reg_free) begin
      if (grant) begin
        bus.usr_arb_tx_wr_valid <= 1'b1;
        bus.usr_arb_tx_wr_addr  <= head[DATA_W+USER_TAG +: ADDR_W];
        bus.usr_arb_tx_wr_tag   <= IF_TAG'({grant_ch, head[DATA_W +: USER_TAG]});
        bus.usr_arb_tx_data     <= head[DATA_W-1:0];
        reg_ch                  <= grant_ch;
        rr_ptr                  <= grant_ch + CH_BITS'(1);
      end else begin
        bus.usr_arb_tx_wr_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_user_tx_wr_if_mc.sv
// Directed bench for user_tx_wr_if_mc: reset, round-robin, credits, backpressure,
// simultaneous issue/response, unsolicited responses and channel flush.
module tb_user_tx_wr_if_mc;
  localparam int NUM_CH = 4, USER_TAG = 7, IF_TAG = 9, ADDR_W = 58, DATA_W = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [IF_TAG-1:0] iss_tag[$];
  logic [ADDR_W-1:0] iss_addr[$];
  logic [DATA_W-1:0] iss_data[$];
  int                iss_cyc[$];
  int                rx_pulses[NUM_CH];

  always #5 clk = ~clk;

  user_tx_wr_if_mc_if #(.NUM_CH(NUM_CH), .USER_TAG(USER_TAG), .IF_TAG(IF_TAG),
                        .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  user_tx_wr_if_mc #(.NUM_CH(NUM_CH), .USER_TAG(USER_TAG), .IF_TAG(IF_TAG), .ADDR_W(ADDR_W),
                     .DATA_W(DATA_W), .FIFO_DEPTH_BITS(5), .MAX_OUTSTANDING(16))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Transfer and response-pulse recorder; checks live in the test tasks.
  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.usr_arb_tx_wr_valid && bus.usr_arb_tx_wr_ready) begin
      iss_tag.push_back(bus.usr_arb_tx_wr_tag);
      iss_addr.push_back(bus.usr_arb_tx_wr_addr);
      iss_data.push_back(bus.usr_arb_tx_data);
      iss_cyc.push_back(cyc);
    end
    for (int c = 0; c < NUM_CH; c++)
      if (!rst && bus.um_rx_wr_valid[c]) rx_pulses[c]++;
  end

  function automatic logic [ADDR_W-1:0] mk_addr(input int ch, input int i);
    return ADDR_W'(64'h1_0000_0000 + 64'(ch * 256 + i));
  endfunction
  function automatic logic [USER_TAG-1:0] mk_tag(input int ch, input int i);
    return USER_TAG'(ch * 32 + i);
  endfunction
  function automatic logic [DATA_W-1:0] mk_data(input int ch, input int i);
    return {64'(ch), 384'd0, 64'(i * 7 + 3)};
  endfunction
  function automatic logic [IF_TAG-1:0] mk_if_tag(input int ch, input logic [USER_TAG-1:0] t);
    return IF_TAG'({2'(ch), t});
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic enqueue(input int ch, input int i);
    bus.um_tx_wr_addr[ch*ADDR_W +: ADDR_W]    = mk_addr(ch, i);
    bus.um_tx_wr_tag[ch*USER_TAG +: USER_TAG] = mk_tag(ch, i);
    bus.um_tx_data[ch*DATA_W +: DATA_W]       = mk_data(ch, i);
    bus.um_tx_wr_valid[ch] = 1'b1;
    tick();
    bus.um_tx_wr_valid[ch] = 1'b0;
  endtask

  task automatic send_rsp(input int ch, input logic [USER_TAG-1:0] t);
    bus.usr_arb_rx_wr_valid = 1'b1;
    bus.usr_arb_rx_wr_tag   = mk_if_tag(ch, t);
    tick();
    bus.usr_arb_rx_wr_valid = 1'b0;
  endtask

  task automatic clear_monitors();
    iss_tag.delete(); iss_addr.delete(); iss_data.delete(); iss_cyc.delete();
    for (int c = 0; c < NUM_CH; c++) rx_pulses[c] = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.reset_interface = '0; bus.um_tx_wr_valid = '0; bus.usr_arb_tx_wr_ready = 1'b0;
    bus.usr_arb_rx_wr_valid = 1'b0; bus.usr_arb_rx_wr_tag = '0;
    tick(2);
    rst = 1'b0;
    tick();
    clear_monitors();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.usr_arb_tx_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", bus.usr_arb_tx_wr_valid); end
    n_checks++; if (bus.usr_tx_wr_if_empty !== 4'hF) begin n_fail++; $display("FAIL rst_empty: got %0h want f", bus.usr_tx_wr_if_empty); end
    n_checks++; if (bus.um_tx_wr_ready !== 4'hF) begin n_fail++; $display("FAIL rst_ready: got %0h want f", bus.um_tx_wr_ready); end
    n_checks++; if (bus.ch_err !== 4'h0) begin n_fail++; $display("FAIL rst_ch_err: got %0h want 0", bus.ch_err); end
    n_checks++; if (bus.usr_arb_tx_wr_tag !== 9'h0 || bus.usr_arb_tx_wr_addr !== '0) begin n_fail++; $display("FAIL rst_outputs: tag %0h addr %0h want 0", bus.usr_arb_tx_wr_tag, bus.usr_arb_tx_wr_addr); end
    enqueue(1, 0); enqueue(1, 1); enqueue(1, 2);
    n_checks++; if (bus.usr_arb_tx_wr_valid !== 1'b1) begin n_fail++; $display("FAIL rst_preload_valid: got %0b want 1", bus.usr_arb_tx_wr_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.usr_arb_tx_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %0b want 0", bus.usr_arb_tx_wr_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_monitors();
    bus.usr_arb_tx_wr_ready = 1'b1;
    tick(8);
    n_checks++; if (iss_tag.size() !== 0) begin n_fail++; $display("FAIL rst_stale_issue: got %0d issued want 0", iss_tag.size()); end
    n_checks++; if (bus.usr_tx_wr_if_empty !== 4'hF) begin n_fail++; $display("FAIL rst_empty_after: got %0h want f", bus.usr_tx_wr_if_empty); end
  endtask

  task automatic test_round_robin();
    int exp_ch[6] = '{0, 2, 3, 0, 2, 3};
    apply_reset();
    enqueue(0, 0); enqueue(0, 1); enqueue(2, 0); enqueue(2, 1); enqueue(3, 0); enqueue(3, 1);
    bus.usr_arb_tx_wr_ready = 1'b1;
    tick(8);
    n_checks++;
    if (iss_tag.size() !== 6) begin
      n_fail++; $display("FAIL rr_count: got %0d want 6", iss_tag.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++; if (iss_tag[k] !== mk_if_tag(exp_ch[k], mk_tag(exp_ch[k], k / 3))) begin n_fail++; $display("FAIL rr_tag[%0d]: got %0h want %0h", k, iss_tag[k], mk_if_tag(exp_ch[k], mk_tag(exp_ch[k], k / 3))); end
        n_checks++; if (iss_addr[k] !== mk_addr(exp_ch[k], k / 3)) begin n_fail++; $display("FAIL rr_addr[%0d]: got %0h want %0h", k, iss_addr[k], mk_addr(exp_ch[k], k / 3)); end
        n_checks++; if (iss_cyc[k] !== iss_cyc[0] + k) begin n_fail++; $display("FAIL rr_back_to_back[%0d]: got cycle %0d want %0d", k, iss_cyc[k], iss_cyc[0] + k); end
      end
      n_checks++; if (iss_data[4] !== mk_data(2, 1)) begin n_fail++; $display("FAIL rr_data: got %0h want %0h", iss_data[4], mk_data(2, 1)); end
    end
  endtask

  task automatic test_credit();
    apply_reset();
    bus.usr_arb_tx_wr_ready = 1'b1;
    for (int i = 0; i < 20; i++) enqueue(1, i);
    tick(10);
    n_checks++; if (iss_tag.size() !== 16) begin n_fail++; $display("FAIL credit_limit: got %0d issued want 16", iss_tag.size()); end
    n_checks++; if (bus.usr_arb_tx_wr_valid !== 1'b0) begin n_fail++; $display("FAIL credit_stall_valid: got %0b want 0", bus.usr_arb_tx_wr_valid); end
    n_checks++; if (bus.usr_tx_wr_if_empty[1] !== 1'b0) begin n_fail++; $display("FAIL credit_empty1: got %0b want 0", bus.usr_tx_wr_if_empty[1]); end
    send_rsp(1, mk_tag(1, 0));
    n_checks++; if (bus.um_rx_wr_valid !== 4'b0010) begin n_fail++; $display("FAIL credit_rx_pulse: got %0b want 0010", bus.um_rx_wr_valid); end
    n_checks++; if (bus.um_rx_wr_tag[USER_TAG +: USER_TAG] !== mk_tag(1, 0)) begin n_fail++; $display("FAIL credit_rx_tag: got %0h want %0h", bus.um_rx_wr_tag[USER_TAG +: USER_TAG], mk_tag(1, 0)); end
    tick();
    n_checks++; if (bus.um_rx_wr_valid !== 4'b0000) begin n_fail++; $display("FAIL credit_rx_one_cycle: got %0b want 0000", bus.um_rx_wr_valid); end
    tick(10);
    n_checks++; if (iss_tag.size() !== 17) begin n_fail++; $display("FAIL credit_one_more: got %0d issued want 17", iss_tag.size()); end
    else begin
      n_checks++; if (iss_tag[16] !== mk_if_tag(1, mk_tag(1, 16))) begin n_fail++; $display("FAIL credit_17th_tag: got %0h want %0h", iss_tag[16], mk_if_tag(1, mk_tag(1, 16))); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 33; i++) enqueue(0, i);
    n_checks++; if (bus.um_tx_wr_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_fifo_full: got ready %0b want 0", bus.um_tx_wr_ready[0]); end
    n_checks++; if (bus.um_tx_wr_ready[3:1] !== 3'b111) begin n_fail++; $display("FAIL bp_other_ready: got %0b want 111", bus.um_tx_wr_ready[3:1]); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (bus.usr_arb_tx_wr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want 1", k, bus.usr_arb_tx_wr_valid); end
      n_checks++; if (bus.usr_arb_tx_wr_addr !== mk_addr(0, 0) || bus.usr_arb_tx_wr_tag !== mk_if_tag(0, mk_tag(0, 0)) || bus.usr_arb_tx_data !== mk_data(0, 0)) begin n_fail++; $display("FAIL bp_hold[%0d]: addr %0h tag %0h want addr %0h tag %0h", k, bus.usr_arb_tx_wr_addr, bus.usr_arb_tx_wr_tag, mk_addr(0, 0), mk_if_tag(0, mk_tag(0, 0))); end
    end
    bus.usr_arb_tx_wr_ready = 1'b1;
    tick(20);
    n_checks++; if (iss_tag.size() !== 16) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 16", iss_tag.size()); end
    else begin
      n_checks++; if (iss_addr[0] !== mk_addr(0, 0) || iss_addr[1] !== mk_addr(0, 1) || iss_addr[15] !== mk_addr(0, 15)) begin n_fail++; $display("FAIL bp_order: got %0h %0h %0h want %0h %0h %0h", iss_addr[0], iss_addr[1], iss_addr[15], mk_addr(0, 0), mk_addr(0, 1), mk_addr(0, 15)); end
    end
    n_checks++; if (bus.um_tx_wr_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %0b want 1", bus.um_tx_wr_ready[0]); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    bus.usr_arb_tx_wr_ready = 1'b1;
    enqueue(2, 0); enqueue(2, 1); enqueue(2, 2);
    tick(4);
    n_checks++; if (iss_tag.size() !== 3) begin n_fail++; $display("FAIL sim_pre_issue: got %0d want 3", iss_tag.size()); end
    bus.usr_arb_tx_wr_ready = 1'b0;
    enqueue(2, 3);
    send_rsp(2, mk_tag(2, 0));
    n_checks++; if (bus.um_rx_wr_valid !== 4'b0100) begin n_fail++; $display("FAIL sim_rx_pulse: got %0b want 0100", bus.um_rx_wr_valid); end
    n_checks++; if (bus.usr_arb_tx_wr_valid !== 1'b1) begin n_fail++; $display("FAIL sim_grant: got %0b want 1", bus.usr_arb_tx_wr_valid); end
    bus.usr_arb_tx_wr_ready = 1'b1;
    tick(2);
    send_rsp(2, mk_tag(2, 1)); send_rsp(2, mk_tag(2, 2));
    tick();
    n_checks++; if (bus.usr_tx_wr_if_empty[2] !== 1'b0) begin n_fail++; $display("FAIL sim_one_left: got empty %0b want 0", bus.usr_tx_wr_if_empty[2]); end
    send_rsp(2, mk_tag(2, 3));
    tick(2);
    n_checks++; if (rx_pulses[2] !== 4) begin n_fail++; $display("FAIL sim_pulses: got %0d want 4", rx_pulses[2]); end
    n_checks++; if (bus.usr_tx_wr_if_empty[2] !== 1'b1) begin n_fail++; $display("FAIL sim_drained: got empty %0b want 1", bus.usr_tx_wr_if_empty[2]); end
    n_checks++; if (bus.ch_err !== 4'b0000) begin n_fail++; $display("FAIL sim_no_err: got %0b want 0000", bus.ch_err); end
    send_rsp(2, 7'h7f);
    send_rsp(3, 7'h55);
    n_checks++; if (bus.um_rx_wr_valid !== 4'b0000) begin n_fail++; $display("FAIL unsol_no_pulse: got %0b want 0000", bus.um_rx_wr_valid); end
    tick(2);
    n_checks++; if (bus.ch_err !== 4'b1100) begin n_fail++; $display("FAIL unsol_ch_err: got %0b want 1100", bus.ch_err); end
    n_checks++; if (rx_pulses[3] !== 0 || rx_pulses[2] !== 4) begin n_fail++; $display("FAIL unsol_pulses: got ch3 %0d ch2 %0d want 0 4", rx_pulses[3], rx_pulses[2]); end
  endtask

  task automatic test_flush();
    apply_reset();
    send_rsp(2, 7'h10);
    n_checks++; if (bus.ch_err[2] !== 1'b1) begin n_fail++; $display("FAIL flush_err_set: got %0b want 1", bus.ch_err[2]); end
    bus.usr_arb_tx_wr_ready = 1'b1;
    enqueue(2, 0); enqueue(2, 1);
    tick(3);
    n_checks++; if (iss_tag.size() !== 2) begin n_fail++; $display("FAIL flush_pre_issue: got %0d want 2", iss_tag.size()); end
    bus.usr_arb_tx_wr_ready = 1'b0;
    for (int i = 2; i < 7; i++) enqueue(2, i);
    n_checks++; if (bus.usr_arb_tx_wr_valid !== 1'b1 || bus.usr_arb_tx_wr_addr !== mk_addr(2, 2)) begin n_fail++; $display("FAIL flush_reg_loaded: valid %0b addr %0h want 1 %0h", bus.usr_arb_tx_wr_valid, bus.usr_arb_tx_wr_addr, mk_addr(2, 2)); end
    bus.reset_interface[2] = 1'b1;
    tick();
    bus.reset_interface[2] = 1'b0;
    n_checks++; if (bus.ch_err[2] !== 1'b0) begin n_fail++; $display("FAIL flush_err_clear: got %0b want 0", bus.ch_err[2]); end
    bus.usr_arb_tx_wr_ready = 1'b1;
    tick(6);
    n_checks++; if (iss_tag.size() !== 3) begin n_fail++; $display("FAIL flush_issue_count: got %0d want 3", iss_tag.size()); end
    else begin
      n_checks++; if (iss_addr[2] !== mk_addr(2, 2)) begin n_fail++; $display("FAIL flush_reg_issued: got %0h want %0h", iss_addr[2], mk_addr(2, 2)); end
    end
    send_rsp(2, mk_tag(2, 0)); send_rsp(2, mk_tag(2, 1));
    tick();
    n_checks++; if (rx_pulses[2] !== 2 || bus.usr_tx_wr_if_empty[2] !== 1'b0) begin n_fail++; $display("FAIL flush_two_rsp: pulses %0d empty %0b want 2 0", rx_pulses[2], bus.usr_tx_wr_if_empty[2]); end
    send_rsp(2, mk_tag(2, 2));
    tick();
    n_checks++; if (rx_pulses[2] !== 3 || bus.usr_tx_wr_if_empty[2] !== 1'b1) begin n_fail++; $display("FAIL flush_drained: pulses %0d empty %0b want 3 1", rx_pulses[2], bus.usr_tx_wr_if_empty[2]); end
    n_checks++; if (bus.ch_err !== 4'b0000) begin n_fail++; $display("FAIL flush_no_err: got %0b want 0000", bus.ch_err); end
  endtask

  initial begin
    bus.reset_interface = '0; bus.um_tx_wr_addr = '0; bus.um_tx_wr_tag = '0;
    bus.um_tx_data = '0; bus.um_tx_wr_valid = '0; bus.usr_arb_tx_wr_ready = 1'b0;
    bus.usr_arb_rx_wr_valid = 1'b0; bus.usr_arb_rx_wr_tag = '0;
    test_reset();
    test_round_robin();
    test_credit();
    test_backpressure();
    test_simultaneous();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
